mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/MEM pipeline register.
- Consumes the registered control (WB, M), ALU result (effective address), store data and destination register.
- Runs a req/ack transaction on the data-memory port, aligns and extends load data, stalls the pipeline while memory is busy, and registers results into the MEM/WB outputs.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 16: WAIT cycles without dmem_ack before abort (min 2).
- ADDR_W, 32: data address width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- WB  in  2  writeback control from EX/MEM, passed through
- M  in  3  memory control: M[1]=MemRead, M[0]=MemWrite, M[2]=Branch (ignored here)
- ALU_status  in  8  ALU flags, passed through
- ALU_result  in  32  effective address / non-memory result
- write_data  in  32  store data (low bits significant)
- RegDst_address  in  5  destination register
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_unsigned  in  1  zero-extend loads when 1
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  transaction complete (rdata valid with it)
- dmem_rdata  in  32  read word
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- mem_exception  out  1  one-cycle pulse on fault
- exc_addr  out  32  faulting address
- out_WB  out  2  MEM/WB writeback control
- out_ALU_status  out  8  registered flags
- out_ALU_result  out  32  registered ALU result
- out_read_data  out  32  aligned, extended load data
- out_RegDst_address  out  5  registered destination

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - All registered outputs 0, mem_exception 0, exc_addr 0.
  - dmem_req/dmem_we drop immediately, including mid-WAIT.
- access = M[1]|M[0]. M=0 is a bubble: outputs register pass-through values, no request.
- Faults, checked combinationally in IDLE:
  - M[1]&M[0] (illegal).
  - mem_size=11.
  - Half with addr[0]=1.
  - Word with addr[1:0]≠0.
- FSM states: IDLE, WAIT.
  - IDLE, access, no fault:
    - dmem_req=1 in the same cycle, driven from the inputs.
    - If dmem_ack is seen that cycle: zero-wait, stall=0, results captured at the edge.
    - Otherwise: latch addr/size/unsigned/data/WB/status/RegDst/we, go to WAIT, reset the counter.
  - WAIT:
    - dmem_req=1, driven from the latched copy; upstream changes are ignored.
    - On ack: capture results, return to IDLE.
    - Counter increments each cycle. At TIMEOUT_CYCLES-1 without ack: deassert req, pulse mem_exception, set exc_addr, out_WB<=0, go to IDLE.
  - IDLE with fault: no request, no stall. Next edge: mem_exception=1 for one cycle, exc_addr<=ALU_result, out_WB<=0.
- stall = dmem_req & ~dmem_ack (combinational). stall is never asserted in a fault cycle.
- While stalled, out_WB<=0 each edge (bubble into WB). Other outputs hold.
- dmem_ack in IDLE with no request: ignored.
- Store lanes (little-endian, lane = addr[1:0]):
  - Byte: be = 1<<lane, wdata = {4{data[7:0]}}.
  - Half: be = 0011 or 1100, wdata = {2{data[15:0]}}.
  - Word: be = 1111, wdata = data.
  - dmem_we = latched M[0].
- Load extraction: select the byte or half at lane from dmem_rdata. Sign-extend unless mem_unsigned. Word passes unchanged. Loads drive be per size.
- Non-load instructions: out_read_data <= 0.
- Latency: one cycle from EX/MEM outputs to MEM/WB outputs with zero-wait memory; 1+N cycles with N wait cycles.

Decomposition:
- Shared package (pipeline_pkg):
  - M bit indices (M_BRANCH=2, M_READ=1, M_WRITE=0).
  - mem_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state enum.
  - WB field widths.
- One natural sub-module: mem_lane_align (combinational). Computes be/wdata from size/lane/data, and extracted/extended load data from rdata/size/lane/unsigned. The FSM, counter and output register stay in the top.

Test Plan:
- LW addr 0x100, size=10, ack same cycle, rdata 0xDEADBEEF, WB=11, RegDst=5 -> stall never 1; next edge out_read_data=0xDEADBEEF, out_WB=11, out_RegDst_address=5.
- LB signed addr 0x103, rdata 0x80112233, ack on 3rd WAIT cycle -> stall=1 for 3 cycles, out_WB=0 during stall; after ack out_read_data=0xFFFFFF80. LBU same access -> 0x00000080.
- SH addr 0x102, write_data 0x1234ABCD -> dmem_we=1, dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x100; no writeback of read data.
- LW addr 0x101 -> dmem_req stays 0, stall 0; next cycle mem_exception=1 (one cycle), exc_addr=0x101, out_WB=00. M=011 gives the same.
- LW addr 0x200, ack withheld, TIMEOUT_CYCLES=16 -> stall high 16 cycles, then req=0, mem_exception pulse, exc_addr=0x200, FSM IDLE. A late ack is ignored.
- rst_n=0 during WAIT cycle 2 -> dmem_req and stall fall asynchronously, all outputs 0. After release, a new LW completes normally.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the MEM stage slice.
// Contents:
//   M_BRANCH/M_READ/M_WRITE - bit positions inside the 3-bit M control field
//   WB_W                    - width of the writeback control field
//   mem_size_e              - load/store access size encodings
//   mem_state_e             - MEM stage transaction FSM states
package pipeline_pkg;

    localparam int M_BRANCH = 2;
    localparam int M_READ   = 1;
    localparam int M_WRITE  = 0;

    localparam int WB_W = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port.
// Signals:
//   dmem_req   - request valid (held until dmem_ack)
//   dmem_we    - write enable
//   dmem_addr  - word-aligned address
//   dmem_be    - byte enables
//   dmem_wdata - lane-replicated store data
//   dmem_ack   - transaction complete, dmem_rdata valid with it
//   dmem_rdata - read word
// Modports: master (pipeline side), slave (memory side).
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage_lane_align.sv
// mem_lane_align: combinational little-endian lane steering.
// Ports:
//   i_size     - access size (byte/half/word; reserved gives all zeros)
//   i_lane     - address bits [1:0]
//   i_wdata    - store data, low bits significant
//   i_rdata    - read word from memory
//   i_unsigned - zero-extend loads when 1, sign-extend otherwise
//   o_be       - byte enables for the access
//   o_wdata    - store data replicated across all lanes
//   o_load     - selected, extended load data
module mem_lane_align
    import pipeline_pkg::*;
(
    input  mem_size_e   i_size,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    input  logic        i_unsigned,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = '0;
        o_wdata = '0;
        o_load  = '0;
        w_byte  = i_rdata[{i_lane, 3'b000} +: 8];
        w_half  = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_load  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_load  = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_load  = i_rdata;
            end
            default: begin
                o_be    = '0;
                o_wdata = '0;
                o_load  = '0;
            end
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between EX/MEM and MEM/WB.
// Issues req/ack data-memory transactions, stalls upstream while memory is
// busy, aligns/extends load data and registers results into MEM/WB.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   WB, M, ALU_status,
//   ALU_result, write_data,
//   RegDst_address,
//   mem_size, mem_unsigned - EX/MEM register contents
//   dmem                   - data-memory port (master side)
//   stall                  - freeze upstream pipeline registers
//   mem_exception,exc_addr - one-cycle fault pulse and faulting address
//   out_*                  - MEM/WB register outputs
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WB_W-1:0] WB,
    input  logic [2:0]      M,
    input  logic [7:0]      ALU_status,
    input  logic [31:0]     ALU_result,
    input  logic [31:0]     write_data,
    input  logic [4:0]      RegDst_address,
    input  logic [1:0]      mem_size,
    input  logic            mem_unsigned,
    mem_access_stage_if.master dmem,
    output logic            stall,
    output logic            mem_exception,
    output logic [31:0]     exc_addr,
    output logic [WB_W-1:0] out_WB,
    output logic [7:0]      out_ALU_status,
    output logic [31:0]     out_ALU_result,
    output logic [31:0]     out_read_data,
    output logic [4:0]      out_RegDst_address
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_result, r_data;
    mem_size_e        r_size;
    logic             r_uns, r_re, r_we;
    logic [WB_W-1:0]  r_wb;
    logic [7:0]       r_status;
    logic [4:0]       r_rd;

    logic             w_in_wait, w_access, w_fault, w_issue, w_timeout, w_done, w_req;
    logic [31:0]      w_sel_result, w_sel_data;
    mem_size_e        w_sel_size;
    logic             w_sel_uns, w_sel_re, w_sel_we;
    logic [WB_W-1:0]  w_sel_wb;
    logic [7:0]       w_sel_status;
    logic [4:0]       w_sel_rd;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata, w_load;
    logic             w_unused_branch;

    assign w_unused_branch = M[M_BRANCH];
    assign w_in_wait       = (r_state == ST_WAIT);
    assign w_access        = M[M_READ] | M[M_WRITE];

    // Faults only matter for a fresh access presented in IDLE.
    assign w_fault = w_access & ((M[M_READ] & M[M_WRITE])
                   | (mem_size == SZ_RSVD)
                   | ((mem_size == SZ_HALF) & ALU_result[0])
                   | ((mem_size == SZ_WORD) & (|ALU_result[1:0])));

    // In WAIT the bus is driven from the latched copy so upstream may change.
    assign w_sel_result = w_in_wait ? r_result : ALU_result;
    assign w_sel_data   = w_in_wait ? r_data   : write_data;
    assign w_sel_size   = w_in_wait ? r_size   : mem_size_e'(mem_size);
    assign w_sel_uns    = w_in_wait ? r_uns    : mem_unsigned;
    assign w_sel_re     = w_in_wait ? r_re     : M[M_READ];
    assign w_sel_we     = w_in_wait ? r_we     : M[M_WRITE];
    assign w_sel_wb     = w_in_wait ? r_wb     : WB;
    assign w_sel_status = w_in_wait ? r_status : ALU_status;
    assign w_sel_rd     = w_in_wait ? r_rd     : RegDst_address;

    assign w_issue   = ~w_in_wait & w_access & ~w_fault;
    // An ack in the last counted cycle still completes the access.
    assign w_timeout = w_in_wait & (r_cnt == CNT_LAST) & ~dmem.dmem_ack;
    // rst_n gating drops the request the moment reset asserts, even from IDLE
    // where the request is otherwise a direct function of the inputs.
    assign w_req     = rst_n & (w_issue | (w_in_wait & ~w_timeout));
    assign w_done    = w_req & dmem.dmem_ack;

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = w_req & w_sel_we;
    assign dmem.dmem_addr  = {w_sel_result[ADDR_W-1:2], 2'b00};
    assign dmem.dmem_be    = w_be;
    assign dmem.dmem_wdata = w_wdata;
    assign stall           = w_req & ~dmem.dmem_ack;

    mem_lane_align u_align (
        .i_size     (w_sel_size),
        .i_lane     (w_sel_result[1:0]),
        .i_wdata    (w_sel_data),
        .i_rdata    (dmem.dmem_rdata),
        .i_unsigned (w_sel_uns),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_load     (w_load)
    );

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_issue && !dmem.dmem_ack) w_state_nx = ST_WAIT;
            ST_WAIT: if (w_done || w_timeout)       w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_data   <= '0;
            r_size   <= SZ_BYTE;
            r_uns    <= 1'b0;
            r_re     <= 1'b0;
            r_we     <= 1'b0;
            r_wb     <= '0;
            r_status <= '0;
            r_rd     <= '0;
        end else if (!w_in_wait && w_issue && !dmem.dmem_ack) begin
            r_cnt    <= '0;
            r_result <= ALU_result;
            r_data   <= write_data;
            r_size   <= mem_size_e'(mem_size);
            r_uns    <= mem_unsigned;
            r_re     <= M[M_READ];
            r_we     <= M[M_WRITE];
            r_wb     <= WB;
            r_status <= ALU_status;
            r_rd     <= RegDst_address;
        end else if (w_in_wait) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_exception      <= 1'b0;
            exc_addr           <= '0;
            out_WB             <= '0;
            out_ALU_status     <= '0;
            out_ALU_result     <= '0;
            out_read_data      <= '0;
            out_RegDst_address <= '0;
        end else begin
            mem_exception <= 1'b0;
            if (w_done) begin
                out_WB             <= w_sel_wb;
                out_ALU_status     <= w_sel_status;
                out_ALU_result     <= w_sel_result;
                out_read_data      <= w_sel_re ? w_load : '0;
                out_RegDst_address <= w_sel_rd;
            end else if (stall) begin
                out_WB <= '0;
            end else if ((!w_in_wait && w_fault) || w_timeout) begin
                mem_exception <= 1'b1;
                exc_addr      <= w_sel_result;
                out_WB        <= '0;
            end else if (!w_in_wait && !w_access) begin
                out_WB             <= WB;
                out_ALU_status     <= ALU_status;
                out_ALU_result     <= ALU_result;
                out_read_data      <= '0;
                out_RegDst_address <= RegDst_address;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_access_stage;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  WB;
    logic [2:0]  M;
    logic [7:0]  ALU_status;
    logic [31:0] ALU_result, write_data;
    logic [4:0]  RegDst_address;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        stall, mem_exception;
    logic [31:0] exc_addr;
    logic [1:0]  out_WB;
    logic [7:0]  out_ALU_status;
    logic [31:0] out_ALU_result, out_read_data;
    logic [4:0]  out_RegDst_address;

    mem_access_stage_if #(.ADDR_W(32)) dmem();

    mem_access_stage #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .WB(WB), .M(M), .ALU_status(ALU_status),
        .ALU_result(ALU_result), .write_data(write_data),
        .RegDst_address(RegDst_address), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .dmem(dmem), .stall(stall),
        .mem_exception(mem_exception), .exc_addr(exc_addr), .out_WB(out_WB),
        .out_ALU_status(out_ALU_status), .out_ALU_result(out_ALU_result),
        .out_read_data(out_read_data), .out_RegDst_address(out_RegDst_address)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [1:0]  wb;
        logic [7:0]  st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  sz;
        logic        uns;
        logic        re;
        logic        we;
    } txn_t;

    txn_t pend, n_pend;
    bit   busy, n_busy;
    int   held, n_held;          // cycles the pending request has been asserted
    logic [1:0]  x_wb, n_wb;
    logic [7:0]  x_st, n_st;
    logic [31:0] x_res, n_res, x_rdat, n_rdat, x_eaddr, n_eaddr;
    logic [4:0]  x_rd, n_rd;
    logic        x_exc, n_exc;
    logic        e_req, e_we, e_stall;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;

    function automatic bit is_fault(logic [2:0] m, logic [1:0] sz, logic [31:0] a);
        int nb;
        if (m[1] && m[0]) return 1;
        if (sz == 2'b11) return 1;
        nb = 1 << sz;
        return (a % nb) != 0;
    endfunction

    function automatic logic [31:0] load_val(logic [31:0] rd, logic [1:0] sz, int lane, logic uns);
        longint v;
        int nb;
        nb = 1 << sz;
        v = longint'(rd >> (8 * lane));
        v = v & ((longint'(1) << (8 * nb)) - 1);
        if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic txn_t cur_txn();
        txn_t t;
        t.wb = WB; t.st = ALU_status; t.addr = ALU_result; t.data = write_data;
        t.rd = RegDst_address; t.sz = mem_size; t.uns = mem_unsigned;
        t.re = M[1]; t.we = M[0];
        return t;
    endfunction

    task automatic model_reset();
        busy = 0; n_busy = 0; held = 0; n_held = 0;
        x_wb = 0; x_st = 0; x_res = 0; x_rdat = 0; x_eaddr = 0; x_rd = 0; x_exc = 0;
        n_wb = 0; n_st = 0; n_res = 0; n_rdat = 0; n_eaddr = 0; n_rd = 0; n_exc = 0;
        e_req = 0; e_we = 0; e_stall = 0; e_addr = 0; e_wdata = 0; e_be = 0;
    endtask

    task automatic serve(input txn_t t, input int h);
        int nb, lane;
        if (h == TO && !dmem.dmem_ack) begin
            n_exc = 1; n_eaddr = t.addr; n_wb = 0; n_busy = 0;
            return;
        end
        nb = 1 << t.sz;
        lane = int'(t.addr % 4);
        e_req = 1; e_we = t.we; e_addr = t.addr - 32'(lane);
        for (int b = 0; b < 4; b++) begin
            e_be[b] = (b >= lane) && (b < lane + nb);
            e_wdata[8*b +: 8] = t.data[8*(b % nb) +: 8];
        end
        if (dmem.dmem_ack) begin
            n_wb = t.wb; n_st = t.st; n_res = t.addr; n_rd = t.rd;
            n_rdat = t.re ? load_val(dmem.dmem_rdata, t.sz, lane, t.uns) : 32'h0;
            n_busy = 0;
        end else begin
            n_wb = 0; n_busy = 1; n_pend = t; n_held = h + 1;
        end
    endtask

    task automatic eval();
        e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
        n_wb = x_wb; n_st = x_st; n_res = x_res; n_rdat = x_rdat; n_rd = x_rd;
        n_eaddr = x_eaddr; n_exc = 0;
        n_busy = busy; n_held = held; n_pend = pend;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (busy) serve(pend, held);
        else if (!(M[1] | M[0])) begin
            n_wb = WB; n_st = ALU_status; n_res = ALU_result; n_rd = RegDst_address; n_rdat = 0;
        end else if (is_fault(M, mem_size, ALU_result)) begin
            n_exc = 1; n_eaddr = ALU_result; n_wb = 0;
        end else serve(cur_txn(), 0);
        e_stall = e_req && !dmem.dmem_ack;
    endtask

    task automatic commit();
        if (!rst_n) model_reset();
        else begin
            x_wb = n_wb; x_st = n_st; x_res = n_res; x_rdat = n_rdat; x_rd = n_rd;
            x_eaddr = n_eaddr; x_exc = n_exc;
            busy = n_busy; held = n_held; pend = n_pend;
        end
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) if (chk_en) begin
        chk("req", dmem.dmem_req, e_req);
        chk("we", dmem.dmem_we, e_we);
        chk("stall", stall, e_stall);
        if (e_req) begin
            chk("addr", dmem.dmem_addr, e_addr);
            chk("be", dmem.dmem_be, e_be);
            chk("wdata", dmem.dmem_wdata, e_wdata);
        end
        chk("exc", mem_exception, x_exc);
        chk("exc_addr", exc_addr, x_eaddr);
        chk("out_WB", out_WB, x_wb);
        chk("out_status", out_ALU_status, x_st);
        chk("out_result", out_ALU_result, x_res);
        chk("out_rdata", out_read_data, x_rdat);
        chk("out_rd", out_RegDst_address, x_rd);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [2:0] m, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input logic [1:0] wb,
                        input logic [4:0] rd, input logic ack, input logic [31:0] rdat);
        @(posedge clk);
        #1;
        commit();
        M = m; mem_size = sz; mem_unsigned = u; ALU_result = a; write_data = d;
        WB = wb; RegDst_address = rd; ALU_status = 8'($urandom);
        dmem.dmem_ack = ack; dmem.dmem_rdata = rdat;
        #1;
        eval();
        chk_en = 1;
    endtask

    task automatic bubble(input logic ack);
        step(3'b000, 2'b00, 1'b0, $urandom, $urandom, 2'b10, 5'd30, ack, $urandom);
    endtask

    task automatic lb_case(input logic u, input logic [31:0] exp);
        int stalls;
        stalls = 0;
        step(3'b010, 2'b00, u, 32'h103, 32'h0, 2'b01, 5'd7, 1'b0, 32'h0);
        stalls += int'(stall);
        repeat (2) begin
            step(3'b001, 2'b10, ~u, 32'hABC, 32'h5555, 2'b10, 5'd9, 1'b0, $urandom);
            stalls += int'(stall);
            chk("lb_wb_stall", out_WB, 2'b00);
        end
        step(3'b001, 2'b10, ~u, 32'hABC, 32'h5555, 2'b10, 5'd9, 1'b1, 32'h80112233);
        stalls += int'(stall);
        chk("lb_stalls", stalls, 3);
        bubble(1'b0);
        chk("lb_rdata", out_read_data, exp);
        chk("lb_wb", out_WB, 2'b01);
    endtask

    initial begin : main
        int stalls, stuck;
        logic [2:0]  rm;
        logic [1:0]  rsz;
        logic [31:0] ra;
        logic        rack;

        model_reset();
        rst_n = 0;
        M = 3'b010; mem_size = 2'b10; mem_unsigned = 0; ALU_result = 32'h100;
        write_data = 0; WB = 2'b11; RegDst_address = 5'd5; ALU_status = 8'hA5;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'h0;
        #12;
        chk("rst_req", dmem.dmem_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_outWB", out_WB, 2'b00);
        chk("rst_rdata", out_read_data, 32'h0);
        chk("rst_exc", mem_exception, 1'b0);
        M = 3'b000;
        #1;
        rst_n = 1;
        eval();

        // LW zero-wait
        step(3'b010, 2'b10, 1'b0, 32'h100, 32'h0, 2'b11, 5'd5, 1'b1, 32'hDEADBEEF);
        chk("lw_stall", stall, 1'b0);
        chk("lw_req", dmem.dmem_req, 1'b1);
        bubble(1'b0);
        chk("lw_rdata", out_read_data, 32'hDEADBEEF);
        chk("lw_wb", out_WB, 2'b11);
        chk("lw_rd", out_RegDst_address, 5'd5);

        // LB / LBU with wait states
        lb_case(1'b0, 32'hFFFFFF80);
        lb_case(1'b1, 32'h00000080);

        // SH lane 2
        step(3'b001, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 2'b00, 5'd3, 1'b1, 32'hFFFFFFFF);
        chk("sh_we", dmem.dmem_we, 1'b1);
        chk("sh_be", dmem.dmem_be, 4'b1100);
        chk("sh_wdata", dmem.dmem_wdata, 32'hABCDABCD);
        chk("sh_addr", dmem.dmem_addr, 32'h100);
        bubble(1'b0);
        chk("sh_rdata", out_read_data, 32'h0);

        // Misaligned LW and illegal M=011
        step(3'b010, 2'b10, 1'b0, 32'h101, 32'h0, 2'b11, 5'd4, 1'b0, 32'h0);
        chk("mis_req", dmem.dmem_req, 1'b0);
        chk("mis_stall", stall, 1'b0);
        bubble(1'b0);
        chk("mis_exc", mem_exception, 1'b1);
        chk("mis_eaddr", exc_addr, 32'h101);
        chk("mis_wb", out_WB, 2'b00);
        bubble(1'b0);
        chk("mis_exc_pulse", mem_exception, 1'b0);
        step(3'b011, 2'b10, 1'b0, 32'h100, 32'h0, 2'b11, 5'd4, 1'b1, 32'h0);
        chk("ill_req", dmem.dmem_req, 1'b0);
        chk("ill_stall", stall, 1'b0);
        bubble(1'b0);
        chk("ill_exc", mem_exception, 1'b1);
        chk("ill_eaddr", exc_addr, 32'h100);
        chk("ill_wb", out_WB, 2'b00);

        // Timeout
        stalls = 0;
        step(3'b010, 2'b10, 1'b0, 32'h200, 32'h0, 2'b11, 5'd6, 1'b0, 32'h0);
        stalls += int'(stall);
        repeat (TO) begin
            bubble(1'b0);
            stalls += int'(stall);
        end
        chk("to_stalls", stalls, TO);
        chk("to_req_drop", dmem.dmem_req, 1'b0);
        bubble(1'b1);
        chk("to_late_ack_req", dmem.dmem_req, 1'b0);
        chk("to_exc", mem_exception, 1'b1);
        chk("to_eaddr", exc_addr, 32'h200);
        chk("to_wb", out_WB, 2'b00);
        bubble(1'b0);
        chk("to_exc_pulse", mem_exception, 1'b0);

        // Reset during WAIT cycle 2
        step(3'b010, 2'b10, 1'b0, 32'h300, 32'h0, 2'b11, 5'd8, 1'b0, 32'h0);
        bubble(1'b0);
        bubble(1'b0);
        chk("rw_req_before", dmem.dmem_req, 1'b1);
        #1;
        rst_n = 0;
        #1;
        chk("rw_req", dmem.dmem_req, 1'b0);
        chk("rw_stall", stall, 1'b0);
        chk("rw_eaddr", exc_addr, 32'h0);
        chk("rw_outWB", out_WB, 2'b00);
        chk("rw_result", out_ALU_result, 32'h0);
        model_reset();
        eval();
        bubble(1'b0);
        rst_n = 1;
        eval();
        step(3'b010, 2'b10, 1'b0, 32'h104, 32'h0, 2'b01, 5'd17, 1'b1, 32'h0BADF00D);
        bubble(1'b0);
        chk("rw_lw_rdata", out_read_data, 32'h0BADF00D);
        chk("rw_lw_wb", out_WB, 2'b01);
        chk("rw_lw_rd", out_RegDst_address, 5'd17);

        // Randomized traffic
        stuck = 0;
        for (int i = 0; i < 3000; i++) begin
            rm   = 3'($urandom);
            rsz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ra   = $urandom;
            if (rsz != 2'b11 && $urandom_range(0, 3) != 0)
                ra = ra & ~((32'd1 << rsz) - 32'd1);
            if (stuck > 0) stuck--;
            else if ($urandom_range(0, 79) == 0) stuck = TO + 4;
            rack = (stuck == 0) && ($urandom_range(0, 2) == 0);
            step(rm, rsz, 1'($urandom), ra, $urandom, 2'($urandom), 5'($urandom), rack, $urandom);
        end

        @(posedge clk);
        #2;
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
